// File: rtl/definitions.sv
// Shared types for the ALU pipe: opcodes, result flags, controller states,
// and the iteration-counter width helper used by the multiplier.
package definitions;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    RSVD = 2'd3
  } opcode_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } alu_state_t;

  // Wide enough to hold WIDTH itself, not just WIDTH-1.
  function automatic int iter_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one partial product per cycle for exactly WIDTH cycles.
// done pulses on the last iteration cycle; product then carries the final value.
module alu_mul_iter
  import definitions::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = iter_cnt_w(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     acc;
  logic               last;

  // Upper half accumulates the multiplicand when the current multiplier bit
  // (prod_q[0]) is set; the extra bit is the carry shifted back in.
  assign acc  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
  assign last = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start && !busy_q) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d = {acc, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = last;
  assign product = prod_d;

endmodule

// File: rtl/alu_pipe.sv
// Single-transaction ALU: ADD/SUB/reserved answer in 1 cycle, MUL in WIDTH+1.
// Result is held in DONE until out_ready; in_ready is registered, so it rises the cycle after.
module alu_pipe
  import definitions::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  opcode_t           op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output alu_flags_t        flags,
  output logic [TAG_W-1:0]  out_tag
);

  alu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  alu_flags_t         flags_q, flags_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               rdy_q, rdy_d;

  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     add_sum, sub_diff;

  assign accept    = in_valid && rdy_q;
  assign add_sum   = {1'b0, a} + {1'b0, b};
  assign sub_diff  = {1'b0, a} - {1'b0, b};
  assign mul_start = accept && (op == MUL) && !mul_busy;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    tag_d    = tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tag_d   = in_tag;
          flags_d = '0;
          state_d = DONE;
          case (op)
            ADD: begin
              result_d      = add_sum[WIDTH-1:0];
              flags_d.carry = add_sum[WIDTH];
            end
            SUB: begin
              result_d      = sub_diff[WIDTH-1:0];
              flags_d.carry = sub_diff[WIDTH];
            end
            MUL: state_d = MUL_BUSY;
            default: begin
              result_d        = '0;
              flags_d.illegal = 1'b1;
            end
          endcase
          flags_d.zero = (result_d == '0);
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          result_d         = mul_product[WIDTH-1:0];
          flags_d          = '0;
          flags_d.overflow = |mul_product[2*WIDTH-1:WIDTH];
          flags_d.zero     = (result_d == '0);
          state_d          = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready follows the next state so that it is a plain flop output.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      tag_q    <= tag_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8, TAG_W=4 with hand-computed expectations.
module tb_alu_pipe;
  import definitions::*;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  opcode_t    op;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  alu_flags_t flags;
  logic [3:0] out_tag;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc;
  logic seen;

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .out_tag   (out_tag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input opcode_t o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [3:0] t);
    op       = o;
    a        = av;
    b        = bv;
    in_tag   = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op        = ADD;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_tag", out_tag, 0);
    step();
    reset_n = 1'b1;
    chk("rel_in_ready_same", in_ready, 0);
    step();
    chk("rel_in_ready_next", in_ready, 1);

    // ADD with carry-out, result taken immediately
    out_ready = 1'b1;
    issue(ADD, 8'hF0, 8'h20, 4'h3);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 8'h10);
    chk("add_flags", flags, 4'b1000);
    chk("add_tag", out_tag, 4'h3);
    chk("add_in_ready_done", in_ready, 0);
    step();
    chk("add_after_valid", out_valid, 0);
    chk("add_after_in_ready", in_ready, 1);

    issue(SUB, 8'h05, 8'h05, 4'h1);
    chk("sub0_result", result, 8'h00);
    chk("sub0_flags", flags, 4'b0100);
    step();

    issue(SUB, 8'h03, 8'h04, 4'h2);
    chk("subb_result", result, 8'hFF);
    chk("subb_flags", flags, 4'b1000);
    step();

    // MUL with overflow; out_ready stays high throughout MUL_BUSY
    issue(MUL, 8'h10, 8'h11, 4'h4);
    wait_valid(20, cyc);
    chk("mul1_latency", cyc + 1, 9);
    chk("mul1_result", result, 8'h10);
    chk("mul1_flags", flags, 4'b0010);
    chk("mul1_tag", out_tag, 4'h4);
    step();

    // MUL while a competing request is presented during busy
    issue(MUL, 8'h0C, 8'h0A, 4'h5);
    op       = ADD;
    a        = 8'hEE;
    b        = 8'h01;
    in_tag   = 4'hF;
    in_valid = 1'b1;
    step();
    chk("mul2_busy_in_ready", in_ready, 0);
    wait_valid(20, cyc);
    chk("mul2_latency", cyc + 2, 9);
    chk("mul2_result", result, 8'h78);
    chk("mul2_flags", flags, 4'b0000);
    chk("mul2_tag", out_tag, 4'h5);
    in_valid = 1'b0;
    step();
    step();
    chk("mul2_no_ghost", {out_valid, in_ready}, 2'b01);

    issue(MUL, 8'h00, 8'h37, 4'h6);
    wait_valid(20, cyc);
    chk("mul0_latency", cyc + 1, 9);
    chk("mul0_result", result, 8'h00);
    chk("mul0_flags", flags, 4'b0100);
    step();

    // Back-pressure with a second request waiting
    out_ready = 1'b0;
    issue(ADD, 8'h01, 8'h02, 4'h7);
    chk("bp_first", {out_valid, result, flags}, {1'b1, 8'h03, 4'b0000});
    op       = SUB;
    a        = 8'h09;
    b        = 8'h04;
    in_tag   = 4'h9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {out_valid, in_ready, result, out_tag}, {1'b1, 1'b0, 8'h03, 4'h7});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    step();
    in_valid = 1'b0;
    chk("bp_second", {out_valid, result, out_tag}, {1'b1, 8'h05, 4'h9});
    step();

    issue(RSVD, 8'h55, 8'h00, 4'h2);
    chk("ill_valid", out_valid, 1);
    chk("ill_result", result, 8'h00);
    chk("ill_flags", flags, 4'b0101);
    step();

    issue(ADD, 8'hFF, 8'h02, 4'h1);
    chk("add2_result", {result, flags}, {8'h01, 4'b1000});
    step();

    // Reset partway through a multiply
    issue(MUL, 8'hFF, 8'hFF, 4'hA);
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mrst_outputs", {out_valid, in_ready, result, flags, out_tag}, 19'd0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("mrst_in_ready_same", in_ready, 0);
    step();
    chk("mrst_in_ready_next", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | out_valid;
    end
    chk("mrst_no_result", {seen, result}, 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 4..64).
REQ-002 SHALL have parameter TAG_W, default 4, width of the caller transaction tag.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  definitions::opcode_t  operation select.
REQ-008 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-009 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-010 SHALL have port in_tag  input  TAG_W  caller tag.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have port flags  output  definitions::alu_flags_t  {carry, zero, overflow, illegal}.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the request that produced result.

Function
REQ-016 SHALL hold one transaction at a time; FSM states IDLE, MUL_BUSY, DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in MUL_BUSY and DONE it SHALL be 0.
REQ-018 Handshake: request accepted on the edge where in_valid && in_ready; op, a, b, in_tag captured then.
REQ-019 Accepted ADD: result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum; IDLE->DONE; out_valid the following cycle (latency 1).
REQ-020 Accepted SUB: result = (a-b) mod 2^WIDTH, carry = borrow (a<b); IDLE->DONE; latency 1.
REQ-021 Accepted MUL: IDLE->MUL_BUSY; shift-add iterator runs exactly WIDTH cycles; then ->DONE; out_valid at latency WIDTH+1.
REQ-022 MUL: result = low WIDTH bits of a*b; overflow = 1 iff high WIDTH bits nonzero; carry = 0.
REQ-023 ADD/SUB: overflow = 0.
REQ-024 Reserved opcode: result = 0, illegal = 1, other flags 0; latency 1.
REQ-025 zero = 1 iff result == 0 (including the illegal case).
REQ-026 In DONE, result, flags, out_tag and out_valid SHALL hold stable until out_ready is sampled 1; then ->IDLE.
REQ-027 out_valid && out_ready on a cycle SHALL make in_ready 1 on the next cycle, not the same cycle (no combinational ready path).
REQ-028 in_valid while in_ready = 0 SHALL be ignored and SHALL NOT corrupt the held transaction; caller must hold it.
REQ-029 Operands a = 0 or b = 0 on MUL SHALL still take the full WIDTH cycles (fixed latency).
REQ-030 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-031 reset_n low SHALL force, asynchronously: state IDLE, out_valid 0, result 0, flags 0, out_tag 0, iteration counter 0.
REQ-032 in_ready SHALL be 0 while reset_n is low and 1 the first cycle after release.
REQ-033 Reset during MUL_BUSY or DONE SHALL discard the transaction; no result emitted after release.

Structure
REQ-034 Package definitions SHALL hold opcode_t (2-bit enum: ADD=0, SUB=1, MUL=2, 3 reserved), alu_flags_t packed struct, and alu_state_t enum.
REQ-035 Iterative multiplier SHALL be a sub-module alu_mul_iter (start, busy, done, WIDTH-parameterised, 2*WIDTH product register, log2(WIDTH)+1 counter).
REQ-036 No multiply operator SHALL be inferred in alu_pipe or alu_mul_iter.

Verification (WIDTH=8, TAG_W=4)
REQ-037 ADD a=0xF0 b=0x20 tag=3, out_ready=1 -> next cycle out_valid, result 0x10, carry 1, zero 0, out_tag 3.
REQ-038 SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry 0; SUB 0x03-0x04 -> 0xFF, carry 1.
REQ-039 MUL a=0x10 b=0x11 -> out_valid exactly 9 cycles after accept, result 0x10, overflow 1; MUL 0x0C*0x0A -> 0x78, overflow 0.
REQ-040 Back-pressure: out_ready=0 for 5 cycles after ADD result; in_valid held with a new request -> result/tag stable, in_ready 0, second request accepted only the cycle after out_ready=1.
REQ-041 Reset mid-MUL (cycle 4 of 8) -> all outputs 0 immediately, no out_valid after release, in_ready 1 one cycle after release.
REQ-042 op=3 a=0x55 -> result 0x00, illegal 1, zero 1, latency 1.
